mul_issue_ctrl: RTL
===================

# mul_issue_ctrl

Issue controller and arbiter for the team's 32x32 pipelined unsigned multiplier. Accepts multiply requests from two requesters with valid/ready handshakes and arbitrates between them round-robin. It converts signed operands to magnitudes and feeds the free-running multiplier pipeline. It tracks in-flight operations with a valid/tag shift register, re-applies the sign at the output, and buffers results in a credit-protected response FIFO so nothing issued is ever dropped.

## Interface
- LAT, 7, multiplier latency in cycles from mul_a/mul_b change to matching mul_z
- TAGW, 4, requester tag width
- RDEPTH, 8, response FIFO depth (power of two, ≥2)
- clk  input  1  clock; all state on rising edge
- reset  input  1  asynchronous, active-low
- req0_valid / req1_valid  input  1  request present
- req0_ready / req1_ready  output  1  request accepted this cycle when valid&ready
- req0_a, req0_b / req1_a, req1_b  input  32  operands
- req0_signed / req1_signed  input  1  1 = two's-complement (MULT), 0 = unsigned (MULTU)
- req0_tag / req1_tag  input  TAGW  opaque tag, returned with result
- mul_a, mul_b  output  32  registered unsigned operands to multiplier
- mul_z  input  64  unsigned product from multiplier
- rsp_valid  output  1  FIFO head valid
- rsp_ready  input  1  consumer pops head when rsp_valid&rsp_ready
- rsp_id  output  1  originating requester (0/1)
- rsp_tag  output  TAGW  tag of the result
- rsp_hi, rsp_lo  output  32  signed/unsigned 64-bit product, upper/lower half
- busy  output  1  any operation in flight or FIFO non-empty

## Operation
- Credit: occ = in-flight count + FIFO count. Issue allowed only when occ < RDEPTH. This guarantees FIFO space at writeback.
- Arbiter: ready for a requester only when issue allowed and it wins. Only one requester is accepted per cycle.
  - One valid: it wins.
  - Both valid: rr pointer picks the winner.
  - rr toggles to point at the loser after every grant. rr resets to 0.
- Issue (accept edge): compute neg = signed & (a[31]^b[31]). Compute magnitudes: |x| = x[31]&signed ? ~x+1 : x. Note that 0x80000000 gives 0x80000000, which is correct as unsigned.
  - mul_a/mul_b load magnitudes.
  - Shift-register stage 0 loads {valid=1, id, tag, neg}.
- Idle cycle (no accept): mul_a/mul_b hold their last value. Stage 0 loads valid=0.
- Shift register: LAT+1 stages, advancing every cycle unconditionally.
- Writeback: when the last stage is valid, mul_z is sampled. Then result = neg ? ~mul_z+1 : mul_z, and {id, tag, result} is pushed to the FIFO.
- FIFO: circular, pointers wrap modulo RDEPTH.
  - Push and pop in the same cycle are both honoured; the count is unchanged.
  - Pop from empty is impossible, because rsp_valid=0.
  - Push when full cannot occur, by the credit rule.
- occ update: +1 on accept, −1 on pop. Accept and pop in the same cycle leave occ unchanged. Writeback moves an entry from in-flight to FIFO, so occ is unchanged.
- Width rules:
  - Signed result is exact for all 32-bit inputs; the range includes −2^31·−2^31 = 2^62.
  - Unsigned result ranges up to (2^32−1)^2.

## Timing
- Accept at edge T:
  - mul_a/mul_b valid from T.
  - mul_z sampled and FIFO written at edge T+LAT+1.
  - rsp_valid high in the cycle after that edge.
  - Accept-to-rsp latency is LAT+2 cycles (9 at default).
- Throughput: one accept per cycle while credits remain. Back-to-back results emerge on consecutive cycles.
- rsp_* come from registered FIFO storage. They stay stable while rsp_valid=1 and rsp_ready=0.
- req*_ready is combinational from registered occ/rr and the current req*_valid. A requester must not make valid depend on ready.
- Reset assertion, including mid-operation, clears immediately:
  - all shift-register valids, FIFO pointers, occ, rr
  - mul_a/mul_b = 0
  - rsp_valid=0, rsp_id=0, rsp_tag=0, rsp_hi/lo=0
  - busy=0, req*_ready=0 while reset is low
  - In-flight operations are discarded without a response.
- After reset release: ready may assert in the first cycle.

## Test plan
- Single signed op: req0 a=0xFFFFFFFD(−3), b=7, signed, tag=5 → after 9 cycles rsp_id=0, tag=5, hi=0xFFFFFFFF, lo=0xFFFFFFEB. busy falls after pop.
- Corner signed/unsigned:
  - a=b=0x80000000 signed → hi=0x40000000, lo=0.
  - a=b=0xFFFFFFFF unsigned → hi=0xFFFFFFFE, lo=0x00000001.
  - a=0x80000000, b=1 signed → hi=0xFFFFFFFF, lo=0x80000000.
- Round-robin: both requesters valid for 6 cycles with rsp_ready=1 → grants alternate 0,1,0,1,0,1. Responses return in issue order with matching tags.
- Backpressure: rsp_ready=0, req0 streams → exactly 8 accepts, then req0_ready=0. Raising rsp_ready for 1 cycle → exactly one more accept. All 9 results are correct and in order.
- Simultaneous accept and pop at occ=RDEPTH−1 → occ stays 7 and no overflow. FIFO pointer wrap after 20 ops → no data corruption.
- Reset mid-operation: assert reset with 3 in flight and 2 in FIFO → all outputs immediately at reset values. After release, no stale responses appear and a new op returns correctly after 9 cycles.

Source files
------------

// File: rtl/mul_issue_ctrl.sv
// mul_issue_ctrl
//
// Issue controller for the shared 32x32 pipelined unsigned multiplier.
// Two requesters compete round-robin for one issue slot per cycle. Signed
// operands are converted to magnitudes before issue. The sign is carried
// alongside the operation in a valid/tag shift register that matches the
// multiplier latency, and it is re-applied at writeback. Results land in a
// response FIFO. A credit counter (in flight + queued) caps the number of
// outstanding operations at the FIFO depth, so a writeback always finds room.
//
// Ports
//   clk, reset              clock, asynchronous active-low reset
//   req{0,1}_valid/ready    request handshake
//   req{0,1}_a/_b           32-bit operands
//   req{0,1}_signed         1 = two's-complement operands, 0 = unsigned
//   req{0,1}_tag            opaque tag returned with the result
//   mul_a, mul_b            registered magnitudes driven to the multiplier
//   mul_z                   unsigned product, LAT cycles after mul_a/mul_b
//   rsp_valid/ready         response handshake (FIFO head)
//   rsp_id, rsp_tag         originating requester and its tag
//   rsp_hi, rsp_lo          64-bit product, upper and lower half
//   busy                    operations in flight or responses queued
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. req*_ready depends on the requester's own valid (and the other
// requester's valid), so a requester must never derive valid from ready.
// rsp_valid only depends on FIFO state, and rsp_* hold still while
// rsp_valid=1 and rsp_ready=0.

module mul_issue_ctrl #(
    parameter int LAT    = 7,
    parameter int TAGW   = 4,
    parameter int RDEPTH = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [31:0]     req0_a,
    input  logic [31:0]     req0_b,
    input  logic            req0_signed,
    input  logic [TAGW-1:0] req0_tag,
    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [31:0]     req1_a,
    input  logic [31:0]     req1_b,
    input  logic            req1_signed,
    input  logic [TAGW-1:0] req1_tag,
    output logic [31:0]     mul_a,
    output logic [31:0]     mul_b,
    input  logic [63:0]     mul_z,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic            rsp_id,
    output logic [TAGW-1:0] rsp_tag,
    output logic [31:0]     rsp_hi,
    output logic [31:0]     rsp_lo,
    output logic            busy
);

    localparam int PW = $clog2(RDEPTH);
    localparam int CW = PW + 1;

    function automatic logic [31:0] magnitude(input logic [31:0] x, input logic s);
        // 0x80000000 maps to itself, which is the right unsigned magnitude.
        return (s & x[31]) ? (~x + 32'd1) : x;
    endfunction

    // ---------------- credit and arbitration ----------------
    logic [CW-1:0] occ;
    logic          rr;
    logic          issue_ok;
    logic          grant0, grant1, accept, pop;

    assign issue_ok = reset && (occ < CW'(RDEPTH));
    // rr names the requester that wins when both are valid.
    assign grant0   = issue_ok & req0_valid & (~req1_valid | ~rr);
    assign grant1   = issue_ok & req1_valid & (~req0_valid |  rr);
    assign accept   = grant0 | grant1;
    assign req0_ready = grant0;
    assign req1_ready = grant1;

    logic [31:0]     sel_a, sel_b;
    logic            sel_signed, sel_neg;
    logic [TAGW-1:0] sel_tag;

    assign sel_a      = grant1 ? req1_a      : req0_a;
    assign sel_b      = grant1 ? req1_b      : req0_b;
    assign sel_signed = grant1 ? req1_signed : req0_signed;
    assign sel_tag    = grant1 ? req1_tag    : req0_tag;
    assign sel_neg    = sel_signed & (sel_a[31] ^ sel_b[31]);

    // ---------------- in-flight shift register ----------------
    logic [LAT:0]    sr_valid;
    logic [LAT:0]    sr_id;
    logic [LAT:0]    sr_neg;
    logic [TAGW-1:0] sr_tag [0:LAT];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sr_valid <= '0;
            sr_id    <= '0;
            sr_neg   <= '0;
            for (int i = 0; i <= LAT; i++) sr_tag[i] <= '0;
            mul_a    <= '0;
            mul_b    <= '0;
        end else begin
            sr_valid <= {sr_valid[LAT-1:0], accept};
            sr_id    <= {sr_id[LAT-1:0], grant1};
            sr_neg   <= {sr_neg[LAT-1:0], sel_neg};
            sr_tag[0] <= sel_tag;
            for (int i = 1; i <= LAT; i++) sr_tag[i] <= sr_tag[i-1];
            if (accept) begin
                mul_a <= magnitude(sel_a, sel_signed);
                mul_b <= magnitude(sel_b, sel_signed);
            end
        end
    end

    logic        wb;
    logic [63:0] wb_res;

    assign wb     = sr_valid[LAT];
    assign wb_res = sr_neg[LAT] ? (~mul_z + 64'd1) : mul_z;

    // ---------------- response FIFO ----------------
    logic            fifo_id  [RDEPTH];
    logic [TAGW-1:0] fifo_tag [RDEPTH];
    logic [63:0]     fifo_res [RDEPTH];
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count;

    assign rsp_valid = (count != '0);
    assign pop       = rsp_valid & rsp_ready;

    // Storage needs no reset: outputs are masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (wb) begin
            fifo_id[wr_ptr]  <= sr_id[LAT];
            fifo_tag[wr_ptr] <= sr_tag[LAT];
            fifo_res[wr_ptr] <= wb_res;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            occ    <= '0;
            rr     <= 1'b0;
        end else begin
            // RDEPTH is a power of two, so pointers wrap by overflow.
            if (wb)  wr_ptr <= wr_ptr + PW'(1);
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            case ({wb, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            // Writeback only moves an entry from in flight to queued.
            case ({accept, pop})
                2'b10:   occ <= occ + CW'(1);
                2'b01:   occ <= occ - CW'(1);
                default: occ <= occ;
            endcase
            if (accept) rr <= grant0;
        end
    end

    assign rsp_id  = rsp_valid & fifo_id[rd_ptr];
    assign rsp_tag = rsp_valid ? fifo_tag[rd_ptr] : '0;
    assign rsp_hi  = rsp_valid ? fifo_res[rd_ptr][63:32] : '0;
    assign rsp_lo  = rsp_valid ? fifo_res[rd_ptr][31:0]  : '0;
    assign busy    = (occ != '0);

endmodule
